// File: rtl/key_blink_pkg.sv
// Shared types and defaults for the key/blink control slice.
package key_blink_pkg;

  localparam int unsigned FILTER_CYCLES_DEF = 1_000_000;
  localparam int unsigned BASE_HALF_DEF     = 25_000_000;
  localparam int unsigned HALF_W            = 25;
  localparam int unsigned SPEED_W           = 2;

  typedef enum logic [1:0] {
    IDLE,
    FILTER_DOWN,
    DOWN,
    FILTER_UP
  } key_state_e;

  // Filter counter width; a filter of one cycle still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [HALF_W-1:0] half_period_of(input int unsigned base,
                                                       input logic [SPEED_W-1:0] sel);
    return HALF_W'((base >> sel) - 1);
  endfunction

endpackage

// File: rtl/key_blink_ctrl_if.sv
// Status bundle from the key control stage to the downstream blink counter.
interface key_blink_ctrl_if;
  import key_blink_pkg::*;

  logic                 Key_state;
  logic                 Key_press;
  logic                 Key_release;
  logic [SPEED_W-1:0]   Speed_sel;
  logic [HALF_W-1:0]    Half_period;

  modport master (
    output Key_state,
    output Key_press,
    output Key_release,
    output Speed_sel,
    output Half_period
  );

  modport slave (
    input Key_state,
    input Key_press,
    input Key_release,
    input Speed_sel,
    input Half_period
  );
endinterface

// File: rtl/key_blink_ctrl_debounce.sv
// Two-flop synchroniser, steady-time filter and press/release FSM for an
// active-low push button.
module key_debounce
  import key_blink_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key_in,
  output logic Key_state,
  output logic Key_press,
  output logic Key_release,
  output logic press_fire
);

  localparam int unsigned     CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  key_state_e    state;
  key_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          release_fire;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= Key_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      Key_state   <= 1'b0;
      Key_press   <= 1'b0;
      Key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      // Registered from the next state so the level lines up with the pulses.
      Key_state   <= (state_nxt == DOWN) || (state_nxt == FILTER_UP);
      Key_press   <= press_fire;
      Key_release <= release_fire;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = '0;
    press_fire   = 1'b0;
    release_fire = 1'b0;
    case (state)
      IDLE: begin
        if (!sync2) state_nxt = FILTER_DOWN;
      end
      FILTER_DOWN: begin
        if (sync2) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = DOWN;
          press_fire = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOWN: begin
        if (sync2) state_nxt = FILTER_UP;
      end
      FILTER_UP: begin
        if (!sync2) begin
          state_nxt = DOWN;
        end else if (cnt == CNT_LAST) begin
          state_nxt    = IDLE;
          release_fire = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/key_blink_ctrl.sv
// Key control stage: debounced button stepping a 2-bit speed selector that
// sets the blink half-period terminal count.
module key_blink_ctrl
  import key_blink_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int unsigned BASE_HALF     = BASE_HALF_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Key_in,
  key_blink_ctrl_if.master   status
);

  logic press_fire;

  key_debounce #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_debounce (
    .Clk         (Clk),
    .Reset       (Reset),
    .Key_in      (Key_in),
    .Key_state   (status.Key_state),
    .Key_press   (status.Key_press),
    .Key_release (status.Key_release),
    .press_fire  (press_fire)
  );

  // Speed steps on the press-accept edge; the interval trails it by one cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      status.Speed_sel   <= '0;
      status.Half_period <= half_period_of(BASE_HALF, '0);
    end else begin
      if (press_fire) status.Speed_sel <= status.Speed_sel + 1'b1;
      status.Half_period <= half_period_of(BASE_HALF, status.Speed_sel);
    end
  end

endmodule

// File: tb/tb_key_blink_ctrl.sv
// Scoreboard bench for key_blink_ctrl with a history-window reference model.
module tb_key_blink_ctrl;

  localparam int unsigned F    = 10;
  localparam int unsigned BASE = 800;

  logic Clk    = 1'b0;
  logic Reset  = 1'b1;
  logic Key_in = 1'b1;

  key_blink_ctrl_if bus ();

  key_blink_ctrl #(
    .FILTER_CYCLES (F),
    .BASE_HALF     (BASE)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Key_in (Key_in),
    .status (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned cyc;
    bit          is_press;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc      = 0;
  bit          armed    = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: the FSM sees the key two samples late; a level is
  // accepted once the last F+1 observed samples all show the opposite level.
  bit          m_s1 = 1'b1;
  bit          m_s2 = 1'b1;
  bit          m_pressed = 1'b0;
  int unsigned m_spd = 0;
  int unsigned m_hp  = BASE - 1;
  bit          obs[$];

  always @(posedge Clk) begin
    bit seen_pressed;
    bit accept;
    cyc++;
    if (Reset) begin
      m_s1      = 1'b1;
      m_s2      = 1'b1;
      m_pressed = 1'b0;
      m_spd     = 0;
      m_hp      = BASE - 1;
      obs.delete();
      armed     = 1'b1;
    end else begin
      m_hp         = (BASE >> m_spd) - 1;
      seen_pressed = !m_s2;
      m_s2         = m_s1;
      m_s1         = Key_in;
      obs.push_back(seen_pressed);
      if (obs.size() > F + 1) void'(obs.pop_front());
      accept = (obs.size() == F + 1);
      foreach (obs[i]) if (obs[i] == m_pressed) accept = 1'b0;
      if (accept) begin
        m_pressed = !m_pressed;
        obs.delete();
        if (m_pressed) m_spd = (m_spd + 1) % 4;
        exp_q.push_back('{cyc: cyc, is_press: m_pressed});
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    bit  exp_p;
    bit  exp_r;
    ev_t ev;
    if (armed) begin
      exp_p = 1'b0;
      exp_r = 1'b0;
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        ev = exp_q.pop_front();
        check("pulse_cycle", ev.cyc, cyc);
        exp_p = ev.is_press;
        exp_r = !ev.is_press;
      end
      check("key_press",   32'(bus.Key_press),   32'(exp_p));
      check("key_release", 32'(bus.Key_release), 32'(exp_r));
      check("key_state",   32'(bus.Key_state),   32'(m_pressed));
      check("speed_sel",   32'(bus.Speed_sel),   m_spd);
      check("half_period", 32'(bus.Half_period), m_hp);
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic hold(input bit v, input int unsigned n);
    Key_in = v;
    repeat (n) step();
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    Reset  = 1'b1;
    Key_in = 1'b1;
    repeat (3) step();
    Reset = 1'b0;
    hold(1'b1, 5);

    // clean press and release
    hold(1'b0, 40);
    hold(1'b1, 40);

    // bounce shorter than the filter
    hold(1'b0, 5);
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 30);

    // four presses wrap the selector
    repeat (4) begin
      hold(1'b0, 20);
      hold(1'b1, 20);
    end

    // reset lands on the terminating filter count
    hold(1'b0, 12);
    pulse_reset();
    hold(1'b0, 30);
    hold(1'b1, 30);

    // long hold, no auto-repeat
    hold(1'b0, 100);
    hold(1'b1, 30);

    // filter boundary: exactly F+2 and F+1 samples low
    hold(1'b0, F + 2);
    hold(1'b1, 30);
    hold(1'b0, F + 1);
    hold(1'b1, 30);

    repeat (150) begin
      if ($urandom_range(0, 19) == 0) pulse_reset();
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 25));
    end
    hold(1'b1, 30);

    check("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
